// File: rtl/mux_sel_pipe_pkg.sv
// Shared defaults and types for the registered select mux and its output buffer.
package mux_sel_pipe_pkg;

  localparam int DEF_WIDTH      = 16;
  localparam int DEF_NUM_INPUTS = 10;
  localparam int DEF_SEL_W      = 5;
  localparam int BEAT_CNT_W     = 16;

  // Buffer occupancy doubles as the state of the buffer controller.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

endpackage

// File: rtl/mux_sel_pipe_skid_buffer_2entry.sv
// Two-entry FIFO with a registered ready, so upstream ready never depends
// combinationally on downstream ready.
module skid_buffer_2entry
  import mux_sel_pipe_pkg::*;
#(
  parameter int WIDTH = 17
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  occ_e             occ_q, occ_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic             in_ready_q, in_ready_d;
  logic             push, pop;

  // Ready is held low for the whole reset cycle so nothing is accepted there.
  assign in_ready  = in_ready_q & ~reset;
  assign out_valid = (occ_q != OCC_EMPTY);
  assign out_data  = head_q;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    occ_d  = occ_q;
    head_d = head_q;
    tail_d = tail_q;
    case (occ_q)
      OCC_EMPTY: begin
        if (push) begin
          head_d = in_data;
          occ_d  = OCC_ONE;
        end
      end
      OCC_ONE: begin
        if (push && pop) begin
          head_d = in_data;
        end else if (push) begin
          tail_d = in_data;
          occ_d  = OCC_FULL;
        end else if (pop) begin
          occ_d = OCC_EMPTY;
        end
      end
      OCC_FULL: begin
        if (pop) begin
          head_d = tail_q;
          occ_d  = OCC_ONE;
        end
      end
      default: occ_d = OCC_EMPTY;
    endcase
    in_ready_d = (occ_d != OCC_FULL);
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all flops update together.
    if (reset) begin
      occ_q      <= OCC_EMPTY;
      // NOTE: payload registers are reset too, so Output reads zero out of reset.
      head_q     <= '0;
      tail_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      occ_q      <= occ_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      in_ready_q <= in_ready_d;
    end
  end

endmodule

// File: rtl/mux_sel_pipe.sv
// Registered N-input select mux: out-of-range selects yield zero and are flagged,
// results pass through a 2-entry buffer, with a sticky error bit and beat counter.
module mux_sel_pipe
  import mux_sel_pipe_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int NUM_INPUTS = DEF_NUM_INPUTS,
  parameter int SEL_W      = DEF_SEL_W
) (
  input  logic                        CLK,
  input  logic                        Reset,
  input  logic [WIDTH*NUM_INPUTS-1:0] In,
  input  logic [SEL_W-1:0]            Op,
  input  logic                        InValid,
  output logic                        InReady,
  output logic [WIDTH-1:0]            Output,
  output logic                        OutOfRange,
  output logic                        OutValid,
  input  logic                        OutReady,
  input  logic                        ErrClear,
  output logic                        ErrSticky,
  output logic [BEAT_CNT_W-1:0]       BeatCount
);

  logic [WIDTH-1:0]      sel_word;
  logic                  oor;
  logic                  accept, deliver;
  logic                  err_sticky_q, err_sticky_d;
  logic [BEAT_CNT_W-1:0] beat_count_q, beat_count_d;

  // Equality decode per input, so an unselected input can never leak into the result.
  always_comb begin
    sel_word = '0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      if (32'(Op) == k) sel_word = In[k*WIDTH +: WIDTH];
    end
  end

  assign oor = (32'(Op) >= NUM_INPUTS);

  skid_buffer_2entry #(
    .WIDTH (WIDTH + 1)
  ) u_buf (
    .clk       (CLK),
    .reset     (Reset),
    .in_valid  (InValid),
    .in_ready  (InReady),
    .in_data   ({oor, sel_word}),
    .out_valid (OutValid),
    .out_ready (OutReady),
    .out_data  ({OutOfRange, Output})
  );

  assign accept  = InValid & InReady;
  assign deliver = OutValid & OutReady;

  always_comb begin
    err_sticky_d = err_sticky_q;
    if (accept && oor)  err_sticky_d = 1'b1;
    else if (ErrClear)  err_sticky_d = 1'b0;
    beat_count_d = deliver ? beat_count_q + BEAT_CNT_W'(1) : beat_count_q;
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      err_sticky_q <= 1'b0;
      beat_count_q <= '0;
    end else begin
      err_sticky_q <= err_sticky_d;
      beat_count_q <= beat_count_d;
    end
  end

  assign ErrSticky = err_sticky_q;
  assign BeatCount = beat_count_q;

endmodule

// File: tb/tb_mux_sel_pipe.sv
// Self-checking bench for mux_sel_pipe: table-driven vectors through a scoreboard,
// hand-written stall/stream/reset sequences, and a narrow second instance.
module tb_mux_sel_pipe;
  import mux_sel_pipe_pkg::*;

  localparam int W = 16;
  localparam int N = 10;
  localparam int S = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [W*N-1:0]   in_bus;
  logic [S-1:0]     op;
  logic             in_valid, in_ready;
  logic [W-1:0]     out_data;
  logic             out_oor, out_valid, out_ready, err_clear, err_sticky;
  logic [15:0]      beat_count;

  logic             rst_s;
  logic [23:0]      in_s;
  logic [1:0]       op_s;
  logic             iv_s, ir_s;
  logic [7:0]       od_s;
  logic             oor_s, ov_s, ordy_s, ec_s, es_s;
  logic [15:0]      bc_s;

  mux_sel_pipe #(.WIDTH(W), .NUM_INPUTS(N), .SEL_W(S)) dut (
    .CLK(clk), .Reset(rst), .In(in_bus), .Op(op), .InValid(in_valid),
    .InReady(in_ready), .Output(out_data), .OutOfRange(out_oor),
    .OutValid(out_valid), .OutReady(out_ready), .ErrClear(err_clear),
    .ErrSticky(err_sticky), .BeatCount(beat_count)
  );

  mux_sel_pipe #(.WIDTH(8), .NUM_INPUTS(3), .SEL_W(2)) dut_s (
    .CLK(clk), .Reset(rst_s), .In(in_s), .Op(op_s), .InValid(iv_s),
    .InReady(ir_s), .Output(od_s), .OutOfRange(oor_s),
    .OutValid(ov_s), .OutReady(ordy_s), .ErrClear(ec_s),
    .ErrSticky(es_s), .BeatCount(bc_s)
  );

  typedef struct packed {
    logic [W-1:0] data;
    logic         oor;
  } beat_t;

  typedef struct {
    logic [S-1:0] op;
    beat_t        exp;
  } vec_t;

  beat_t       sb_q[$];
  vec_t        vt[14];
  int          total = 0;
  int          bad   = 0;
  logic [15:0] m_cnt;
  logic        m_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic beat_t exp_sel(input logic [S-1:0] o);
    beat_t b;
    if (o < N) begin
      b.data = 16'h1000 + 16'(o);
      b.oor  = 1'b0;
    end else begin
      b.data = '0;
      b.oor  = 1'b1;
    end
    return b;
  endfunction

  // One clock: drive, check the state about to be sampled, then advance the model.
  task automatic cycle(input logic v, input logic [S-1:0] o, input logic ordy,
                       input logic clr, input beat_t exp);
    logic deliver, accept;
    @(negedge clk);
    in_valid = v; op = o; out_ready = ordy; err_clear = clr;
    #1;
    check("in_ready", in_ready, 32'(sb_q.size() < 2));
    check("out_valid", out_valid, 32'(sb_q.size() > 0));
    check("beat_count", beat_count, m_cnt);
    check("err_sticky", err_sticky, m_err);
    if (sb_q.size() > 0) begin
      check("head_data", out_data, sb_q[0].data);
      check("head_oor", out_oor, sb_q[0].oor);
    end
    deliver = (sb_q.size() > 0) && ordy;
    accept  = v && (sb_q.size() < 2);
    if (deliver) begin
      void'(sb_q.pop_front());
      m_cnt++;
    end
    if (accept) sb_q.push_back(exp);
    if (accept && exp.oor) m_err = 1'b1;
    else if (clr)          m_err = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; op = '0; out_ready = 1'b1; err_clear = 1'b0;
    #1;
    check("in_ready_in_reset", in_ready, 0);
    @(negedge clk);
    rst = 1'b0; rst_s = 1'b0; in_valid = 1'b0;
    sb_q.delete();
    m_cnt = '0;
    m_err = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_beat_count", beat_count, 0);
    check("rst_err_sticky", err_sticky, 0);
    check("rst_in_ready", in_ready, 1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; op = '0; out_ready = 1'b0; err_clear = 1'b0;
    rst_s = 1'b1; iv_s = 1'b0; op_s = '0; ordy_s = 1'b0; ec_s = 1'b0;
    in_s = {8'hC2, 8'hB1, 8'hA0};
    m_cnt = '0; m_err = 1'b0;
    for (int k = 0; k < N; k++) in_bus[k*W +: W] = 16'h1000 + 16'(k);

    do_reset();
    check("rst_out_data", out_data, 0);
    check("rst_out_oor", out_oor, 0);

    for (int k = 0; k < 10; k++) begin
      vt[k].op  = S'(k);
      vt[k].exp = '{data: 16'h1000 + 16'(k), oor: 1'b0};
    end
    vt[10] = '{op: 5'd12, exp: '{data: 16'h0000, oor: 1'b1}};
    vt[11] = '{op: 5'd15, exp: '{data: 16'h0000, oor: 1'b1}};
    vt[12] = '{op: 5'd31, exp: '{data: 16'h0000, oor: 1'b1}};
    vt[13] = '{op: 5'd9,  exp: '{data: 16'h1009, oor: 1'b0}};
    for (int i = 0; i < 14; i++) cycle(1'b1, vt[i].op, 1'b1, 1'b0, vt[i].exp);
    cycle(1'b0, '0, 1'b1, 1'b0, '0);
    cycle(1'b0, '0, 1'b1, 1'b0, '0);
    check("beat_count_table", beat_count, 16'd14);
    check("err_after_oor", err_sticky, 1);

    cycle(1'b0, '0, 1'b1, 1'b1, '0);
    cycle(1'b0, '0, 1'b1, 1'b0, '0);
    check("err_cleared", err_sticky, 0);
    cycle(1'b1, 5'd12, 1'b1, 1'b1, exp_sel(5'd12));
    cycle(1'b0, '0, 1'b1, 1'b0, '0);
    check("err_set_wins", err_sticky, 1);
    cycle(1'b0, '0, 1'b1, 1'b1, '0);

    // Downstream stall: A and B fill the buffer, C must be held off.
    cycle(1'b1, 5'd1, 1'b0, 1'b0, exp_sel(5'd1));
    cycle(1'b1, 5'd2, 1'b0, 1'b0, exp_sel(5'd2));
    cycle(1'b1, 5'd3, 1'b0, 1'b0, exp_sel(5'd3));
    check("stall_in_ready_low", in_ready, 0);
    cycle(1'b1, 5'd3, 1'b0, 1'b0, exp_sel(5'd3));
    check("stall_head_a", out_data, 16'h1001);
    cycle(1'b1, 5'd3, 1'b1, 1'b0, exp_sel(5'd3));
    cycle(1'b1, 5'd3, 1'b1, 1'b0, exp_sel(5'd3));
    cycle(1'b0, '0, 1'b1, 1'b0, '0);
    check("stall_head_c", out_data, 16'h1003);
    cycle(1'b0, '0, 1'b1, 1'b0, '0);

    // Full-rate stream at occupancy 1.
    cycle(1'b1, 5'd0, 1'b0, 1'b0, exp_sel(5'd0));
    for (int i = 0; i < 20; i++) begin
      logic [S-1:0] o;
      o = S'($urandom_range(0, 31));
      cycle(1'b1, o, 1'b1, 1'b0, exp_sel(o));
      check("stream_no_bubble", 32'(out_valid && in_ready), 1);
    end
    cycle(1'b0, '0, 1'b1, 1'b0, '0);
    cycle(1'b0, '0, 1'b1, 1'b1, '0);
    cycle(1'b0, '0, 1'b1, 1'b0, '0);

    // Reset with the buffer full and the error bit set.
    cycle(1'b1, 5'd4, 1'b0, 1'b0, exp_sel(5'd4));
    cycle(1'b1, 5'd20, 1'b0, 1'b0, exp_sel(5'd20));
    cycle(1'b0, '0, 1'b0, 1'b0, '0);
    check("full_before_reset", in_ready, 0);
    do_reset();
    cycle(1'b1, 5'd7, 1'b1, 1'b0, exp_sel(5'd7));
    cycle(1'b0, '0, 1'b1, 1'b0, '0);
    cycle(1'b0, '0, 1'b1, 1'b0, '0);

    // Narrow instance: WIDTH=8, NUM_INPUTS=3, SEL_W=2.
    @(negedge clk);
    iv_s = 1'b1; op_s = 2'd3; ordy_s = 1'b1;
    #1;
    check("s_in_ready", ir_s, 1);
    check("s_out_valid_idle", ov_s, 0);
    @(negedge clk);
    op_s = 2'd2;
    #1;
    check("s_oor_data", od_s, 8'h00);
    check("s_oor_flag", oor_s, 1);
    check("s_oor_valid", ov_s, 1);
    @(negedge clk);
    iv_s = 1'b0;
    #1;
    check("s_in2_data", od_s, 8'hC2);
    check("s_in2_flag", oor_s, 0);
    @(negedge clk);
    #1;
    check("s_drained", ov_s, 0);
    check("s_beat_count", bc_s, 2);
    check("s_err_sticky", es_s, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
